// File: rtl/tour_cmd.sv
// Replays the solver's tour as vertical/horizontal drive commands; a UART passthrough mux in idle.
// Optional build macro TOUR_CMD_FANFARE_EN: horizontal legs use the fanfare opcode.
module tour_cmd #(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        clr_uart_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [3:0] OpMove = 4'b0100;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OpHorz = 4'b0101;
`else
  localparam logic [3:0] OpHorz = 4'b0100;
`endif
  localparam logic [7:0] HdNorth = 8'h00;
  localparam logic [7:0] HdWest  = 8'h3F;
  localparam logic [7:0] HdSouth = 8'h7F;
  localparam logic [7:0] HdEast  = 8'hBF;
  localparam logic [4:0] LastIdx = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {StIdle, StVert, StWaitV, StHorz, StWaitH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [7:0]  move_q, move_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  // Lowest set bit wins; an empty move yields zero-length north/east legs.
  function automatic logic [15:0] vert_leg(input logic [7:0] m);
    casez (m)
      8'b???????1: vert_leg = {OpMove, HdNorth, 4'd1};
      8'b??????10: vert_leg = {OpMove, HdNorth, 4'd2};
      8'b?????100: vert_leg = {OpMove, HdNorth, 4'd2};
      8'b????1000: vert_leg = {OpMove, HdNorth, 4'd1};
      8'b???10000: vert_leg = {OpMove, HdSouth, 4'd1};
      8'b??100000: vert_leg = {OpMove, HdSouth, 4'd2};
      8'b?1000000: vert_leg = {OpMove, HdSouth, 4'd2};
      8'b10000000: vert_leg = {OpMove, HdSouth, 4'd1};
      default:     vert_leg = {OpMove, HdNorth, 4'd0};
    endcase
  endfunction

  function automatic logic [15:0] horz_leg(input logic [7:0] m);
    casez (m)
      8'b???????1: horz_leg = {OpHorz, HdEast, 4'd2};
      8'b??????10: horz_leg = {OpHorz, HdEast, 4'd1};
      8'b?????100: horz_leg = {OpHorz, HdWest, 4'd1};
      8'b????1000: horz_leg = {OpHorz, HdWest, 4'd2};
      8'b???10000: horz_leg = {OpHorz, HdWest, 4'd2};
      8'b??100000: horz_leg = {OpHorz, HdWest, 4'd1};
      8'b?1000000: horz_leg = {OpHorz, HdEast, 4'd1};
      8'b10000000: horz_leg = {OpHorz, HdEast, 4'd2};
      default:     horz_leg = {OpHorz, HdEast, 4'd0};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    move_d    = move_q;
    cmd_d     = cmd_q;
    unique case (state_q)
      StIdle: begin
        if (start_tour) begin
          state_d   = StVert;
          mv_indx_d = '0;
          move_d    = move;
          cmd_d     = vert_leg(move);
        end
      end
      StVert: begin
        if (clr_cmd_rdy) state_d = StWaitV;
      end
      StWaitV: begin
        if (send_resp) begin
          state_d = StHorz;
          cmd_d   = horz_leg(move_q);
        end
      end
      StHorz: begin
        if (clr_cmd_rdy) state_d = StWaitH;
      end
      StWaitH: begin
        if (send_resp) begin
          if (mv_indx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            state_d   = StVert;
            mv_indx_d = mv_indx_q + 5'd1;
            move_d    = move;
            cmd_d     = vert_leg(move);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_rdy_d = (state_d == StVert) || (state_d == StHorz);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mv_indx_q <= '0;
      move_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      move_q    <= move_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    if (state_q == StIdle) begin
      cmd          = cmd_UART;
      cmd_rdy      = cmd_rdy_UART;
      clr_uart_rdy = clr_cmd_rdy;
    end else begin
      cmd          = cmd_q;
      cmd_rdy      = cmd_rdy_q;
      clr_uart_rdy = 1'b0;
    end
    resp = ((state_q == StIdle) || ((state_q == StWaitH) && (mv_indx_q == LastIdx))) ?
           8'hA5 : 8'h5A;
  end

  assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd; a move-vector reference model predicts every replayed command.
module tb_tour_cmd;
  localparam int NumMoves = 24;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HorzOp = 4'b0101;
`else
  localparam logic [3:0] HorzOp = 4'b0100;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move = '0;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = '0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        clr_uart_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;
  int dx_tab[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int dy_tab[8] = '{1, 2, 2, 1, -1, -2, -2, -1};

  tour_cmd #(.NUM_MOVES(NumMoves)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .clr_uart_rdy(clr_uart_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .resp(resp)
  );

  always #5 clk = ~clk;

  // Knight displacement of the lowest set bit, turned into one leg.
  function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horiz);
    int dx = 0;
    int dy = 0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        dx = dx_tab[i];
        dy = dy_tab[i];
      end
    end
    if (horiz) return {HorzOp, (dx >= 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    return {4'b0100, (dy >= 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  function automatic logic [7:0] rand_move();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 8'h00;
    if (sel < 3) return 8'($urandom);
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic begin_tour(input logic [7:0] mv);
    move = mv; start_tour = 1;
    tick();
    start_tour = 0;
  endtask

  // Drives one full move from VERT through to the next VERT (or IDLE after the last one).
  task automatic replay_move(input logic [7:0] mv, input logic [7:0] nxt, input int idx);
    logic [15:0] ev = exp_leg(mv, 1'b0);
    logic [15:0] eh = exp_leg(mv, 1'b1);
    logic [7:0] er = (idx == NumMoves - 1) ? 8'hA5 : 8'h5A;
    bit both = 1'($urandom_range(0, 1));
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== ev)
      begin failures++; $display("FAIL vert_cmd idx=%0d: got rdy=%b cmd=%h want rdy=1 cmd=%h",
                                 idx, cmd_rdy, cmd, ev); end
    checks++;
    if (mv_indx !== 5'(idx))
      begin failures++; $display("FAIL mv_indx: got %0d want %0d", mv_indx, idx); end
    move = 8'($urandom); send_resp = 1;
    tick();
    send_resp = 0;
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== ev || resp !== 8'h5A || clr_uart_rdy !== 1'b0)
      begin failures++; $display("FAIL vert_hold idx=%0d: got rdy=%b cmd=%h resp=%h want 1 %h 5a",
                                 idx, cmd_rdy, cmd, resp, ev); end
    clr_cmd_rdy = 1; send_resp = both;
    tick();
    clr_cmd_rdy = 0; send_resp = 0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== ev || clr_uart_rdy !== 1'b0)
      begin failures++; $display("FAIL wait_v idx=%0d: got rdy=%b cmd=%h want 0 %h",
                                 idx, cmd_rdy, cmd, ev); end
    tick();
    checks++;
    if (cmd_rdy !== 1'b0)
      begin failures++; $display("FAIL wait_v_hold idx=%0d: got rdy=%b want 0", idx, cmd_rdy); end
    send_resp = 1;
    tick();
    send_resp = 0;
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== eh || resp !== 8'h5A)
      begin failures++; $display("FAIL horz_cmd idx=%0d: got rdy=%b cmd=%h resp=%h want 1 %h 5a",
                                 idx, cmd_rdy, cmd, resp, eh); end
    clr_cmd_rdy = 1;
    tick();
    clr_cmd_rdy = 0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== eh || resp !== er)
      begin failures++; $display("FAIL wait_h idx=%0d: got rdy=%b cmd=%h resp=%h want 0 %h %h",
                                 idx, cmd_rdy, cmd, resp, eh, er); end
    move = nxt; send_resp = 1;
    tick();
    send_resp = 0;
  endtask

  task automatic check_idle_mux(input string name);
    for (int i = 0; i < 4; i++) begin
      cmd_UART = (i == 0) ? 16'h4013 : 16'($urandom);
      cmd_rdy_UART = (i == 0) ? 1'b1 : 1'($urandom);
      clr_cmd_rdy = 1'($urandom);
      #1;
      checks++;
      if (cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART || clr_uart_rdy !== clr_cmd_rdy ||
          resp !== 8'hA5)
        begin failures++; $display("FAIL %s: got cmd=%h rdy=%b clr=%b resp=%h want %h %b %b a5",
                                   name, cmd, cmd_rdy, clr_uart_rdy, resp, cmd_UART,
                                   cmd_rdy_UART, clr_cmd_rdy); end
      tick();
    end
    clr_cmd_rdy = 0; cmd_rdy_UART = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mv_indx !== 5'd0)
      begin failures++; $display("FAIL reset_indx: got %0d want 0", mv_indx); end
    check_idle_mux("reset_mux");
  endtask

  task automatic test_single_move(input logic [7:0] mv);
    begin_tour(mv);
    replay_move(mv, 8'h00, 0);
    checks++;
    if (mv_indx !== 5'd1 || cmd_rdy !== 1'b1 || cmd !== exp_leg(8'h00, 1'b0))
      begin failures++; $display("FAIL next_move: got idx=%0d rdy=%b cmd=%h want 1 1 %h",
                                 mv_indx, cmd_rdy, cmd, exp_leg(8'h00, 1'b0)); end
    do_reset();
  endtask

  task automatic test_ignore_in_wait();
    logic [7:0] mv = rand_move();
    begin_tour(mv);
    clr_cmd_rdy = 1;
    tick();
    clr_cmd_rdy = 0;
    start_tour = 1; cmd_rdy_UART = 1; cmd_UART = 16'($urandom); clr_cmd_rdy = 1;
    #1;
    checks++;
    if (clr_uart_rdy !== 1'b0 || cmd_rdy !== 1'b0 || cmd !== exp_leg(mv, 1'b0))
      begin failures++; $display("FAIL wait_v_ignore: got clr=%b rdy=%b cmd=%h want 0 0 %h",
                                 clr_uart_rdy, cmd_rdy, cmd, exp_leg(mv, 1'b0)); end
    tick();
    start_tour = 0; cmd_rdy_UART = 0; clr_cmd_rdy = 0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== exp_leg(mv, 1'b0) || mv_indx !== 5'd0)
      begin failures++; $display("FAIL no_restart: got rdy=%b cmd=%h idx=%0d want 0 %h 0",
                                 cmd_rdy, cmd, mv_indx, exp_leg(mv, 1'b0)); end
    send_resp = 1;
    tick();
    send_resp = 0;
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_leg(mv, 1'b1))
      begin failures++; $display("FAIL resume_horz: got rdy=%b cmd=%h want 1 %h",
                                 cmd_rdy, cmd, exp_leg(mv, 1'b1)); end
    do_reset();
  endtask

  task automatic test_full_tour();
    logic [7:0] tour [NumMoves];
    logic [7:0] mv;
    for (int k = 0; k < NumMoves; k++) tour[k] = rand_move();
    begin_tour(tour[0]);
    for (int k = 0; k < NumMoves; k++)
      replay_move(tour[k], (k < NumMoves - 1) ? tour[k + 1] : 8'($urandom), k);
    checks++;
    if (mv_indx !== 5'(NumMoves - 1))
      begin failures++; $display("FAIL end_indx: got %0d want %0d", mv_indx, NumMoves - 1); end
    check_idle_mux("end_mux");
    mv = rand_move();
    begin_tour(mv);
    checks++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== exp_leg(mv, 1'b0))
      begin failures++; $display("FAIL restart: got idx=%0d rdy=%b cmd=%h want 0 1 %h",
                                 mv_indx, cmd_rdy, cmd, exp_leg(mv, 1'b0)); end
    do_reset();
  endtask

  task automatic test_reset_mid_tour();
    logic [7:0] tour [8];
    for (int k = 0; k < 8; k++) tour[k] = rand_move();
    begin_tour(tour[0]);
    for (int k = 0; k < 7; k++) replay_move(tour[k], tour[k + 1], k);
    clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
    send_resp = 1; tick(); send_resp = 0;
    checks++;
    if (mv_indx !== 5'd7 || cmd_rdy !== 1'b1 || cmd !== exp_leg(tour[7], 1'b1))
      begin failures++; $display("FAIL horz_7: got idx=%0d rdy=%b cmd=%h want 7 1 %h",
                                 mv_indx, cmd_rdy, cmd, exp_leg(tour[7], 1'b1)); end
    cmd_UART = 16'($urandom); cmd_rdy_UART = 1'($urandom);
    rst_n = 0;
    #1;
    checks++;
    if (mv_indx !== 5'd0 || cmd_rdy !== cmd_rdy_UART || cmd !== cmd_UART || resp !== 8'hA5)
      begin failures++; $display("FAIL abort: got idx=%0d rdy=%b cmd=%h resp=%h want 0 %b %h a5",
                                 mv_indx, cmd_rdy, cmd, resp, cmd_rdy_UART, cmd_UART); end
    tick();
    rst_n = 1;
    tick();
    check_idle_mux("abort_mux");
  endtask

  initial begin
    test_reset();
    test_single_move(8'h01);
    test_single_move(8'h20);
    test_single_move(8'h00);
    test_single_move(8'h6C);
    test_ignore_in_wait();
    test_full_tour();
    test_full_tour();
    test_reset_mid_tour();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
